mac4_dot_seq: RTL and testbench

Sequencer that computes a length-programmable dot product of 4-bit unsigned operand pairs using the team's combinational 4-bit MAC (a*b + c, 12-bit result plus carry-out). The block owns the 12-bit accumulator register and drives the MAC's a, b and c inputs. It accepts operand pairs on a valid/ready stream and presents the final sum on a valid/ready result port. It sits between the operand fetch logic and the result consumer in the AI-chip datapath.

---
 rtl/mac4_dot_seq_if.sv | 33 +++
 rtl/mac4_dot_seq.sv | 114 +++++++++++
 tb/tb_mac4_dot_seq.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/mac4_dot_seq_if.sv
// Operand stream, result stream and MAC operand/result bus for mac4_dot_seq.
// No latency of its own; it only groups wires.
// Backpressure: in_ready/out_ready are carried here alongside their valids.
interface mac4_dot_seq_if;
  // operand pair stream
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_a;
  logic [3:0]  in_b;
  // result stream
  logic        out_valid;
  logic        out_ready;
  logic [11:0] out_sum;
  logic        out_ovf;
  // external combinational MAC (a*b + c)
  logic [3:0]  mac_a;
  logic [3:0]  mac_b;
  logic [11:0] mac_c;
  logic [11:0] mac_result;
  logic        mac_cout;

  // Producer/consumer/MAC side
  modport master (
    output in_valid, in_a, in_b, out_ready, mac_result, mac_cout,
    input  in_ready, out_valid, out_sum, out_ovf, mac_a, mac_b, mac_c
  );

  // Sequencer side
  modport slave (
    input  in_valid, in_a, in_b, out_ready, mac_result, mac_cout,
    output in_ready, out_valid, out_sum, out_ovf, mac_a, mac_b, mac_c
  );
endinterface

// File: rtl/mac4_dot_seq.sv
// Dot-product sequencer: streams 4-bit pairs through an external MAC into a 12-bit accumulator.
// Latency: result valid the cycle after the last accepted pair; one pair per cycle.
// Backpressure: in_ready high only while accumulating; result held in DONE until out_ready.
module mac4_dot_seq #(
  parameter int LEN_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic             abort,
  output logic             busy,
  mac4_dot_seq_if.slave    io
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [11:0]      acc_q, acc_d;
  logic             ovf_q, ovf_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic             last_beat;

  // The pair being accepted now is the final one of the job.
  assign last_beat = ((cnt_q + LEN_W'(1)) == len_q);

  // State, accumulator, sticky overflow, beat counter and latched length.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
      len_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      ovf_q   <= ovf_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
    end
  end

  // Next-state and output decode; abort outranks both beat acceptance and out_ready.
  always_comb begin
    state_d      = state_q;
    acc_d        = acc_q;
    ovf_d        = ovf_q;
    cnt_d        = cnt_q;
    len_d        = len_q;
    busy         = 1'b0;
    io.in_ready  = 1'b0;
    io.out_valid = 1'b0;
    io.out_sum   = '0;
    io.out_ovf   = 1'b0;
    io.mac_a     = '0;
    io.mac_b     = '0;
    io.mac_c     = '0;

    case (state_q)
      IDLE: begin
        if (start) begin
          acc_d = '0;
          ovf_d = 1'b0;
          if (len != '0) begin
            len_d   = len;
            cnt_d   = '0;
            state_d = ACC;
          end else begin
            state_d = DONE;
          end
        end
      end

      ACC: begin
        busy        = 1'b1;
        io.in_ready = 1'b1;
        io.mac_a    = io.in_a;
        io.mac_b    = io.in_b;
        io.mac_c    = acc_q;
        if (abort) begin
          state_d = IDLE;
        end else if (io.in_valid) begin
          acc_d = io.mac_result;
          ovf_d = ovf_q | io.mac_cout;
          cnt_d = cnt_q + LEN_W'(1);
          if (last_beat) begin
            state_d = DONE;
          end
        end
      end

      DONE: begin
        busy         = 1'b1;
        io.out_valid = 1'b1;
        io.out_sum   = acc_q;
        io.out_ovf   = ovf_q;
        if (abort || io.out_ready) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_mac4_dot_seq.sv
// Self-checking bench for mac4_dot_seq: directed and random jobs against an arithmetic reference.
// The external MAC is modelled combinationally here.
// Inputs change on the falling edge; outputs are checked 1 time unit after that.
module tb_mac4_dot_seq;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [4:0] len;
  logic       abort;
  logic       busy;

  mac4_dot_seq_if io ();

  mac4_dot_seq #(.LEN_W(5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .len   (len),
    .abort (abort),
    .busy  (busy),
    .io    (io)
  );

  // combinational MAC: a*b + c with 12-bit result and carry-out
  logic [12:0] mac_full;
  assign mac_full      = 13'(io.mac_a) * 13'(io.mac_b) + 13'(io.mac_c);
  assign io.mac_result = mac_full[11:0];
  assign io.mac_cout   = mac_full[12];

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;
  int qa[$];
  int qb[$];

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_busy"}, 16'(busy), 16'd0);
    chk({tag, "_ordy"}, 16'(io.in_ready), 16'd0);
    chk({tag, "_ovld"}, 16'(io.out_valid), 16'd0);
    chk({tag, "_osum"}, 16'(io.out_sum), 16'd0);
    chk({tag, "_macc"}, 16'(io.mac_c), 16'd0);
  endtask

  // Run one job with the pairs in qa/qb. Reference: plain sum of products;
  // overflow happens iff the unwrapped total ever reaches 4096.
  task automatic run_job(input int n, input int stall_fix, input int stall_rand, input int hold);
    int total = 0;
    start = 1'b1;
    len   = 5'(n);
    step();
    start = 1'b0;
    len   = 5'($urandom);
    for (int k = 0; k < n; k++) begin
      if (k > 0) begin
        int st = stall_fix + int'($urandom_range(0, stall_rand));
        io.in_valid = 1'b0;
        for (int s = 0; s < st; s++) begin
          #1;
          chk("stall_in_ready", 16'(io.in_ready), 16'd1);
          chk("stall_out_valid", 16'(io.out_valid), 16'd0);
          step();
        end
      end
      io.in_valid = 1'b1;
      io.in_a     = 4'(qa[k]);
      io.in_b     = 4'(qb[k]);
      #1;
      chk("beat_in_ready", 16'(io.in_ready), 16'd1);
      chk("beat_busy", 16'(busy), 16'd1);
      chk("beat_mac_a", 16'(io.mac_a), 16'(qa[k]));
      chk("beat_mac_c", 16'(io.mac_c), 16'(total % 4096));
      chk("beat_cout", 16'(io.mac_cout), 16'(((total % 4096) + qa[k] * qb[k]) >= 4096));
      total += qa[k] * qb[k];
      step();
    end
    io.in_valid = 1'b0;
    io.in_a     = 4'($urandom);
    io.in_b     = 4'($urandom);
    io.out_ready = 1'b0;
    for (int h = 0; h <= hold; h++) begin
      #1;
      chk("done_out_valid", 16'(io.out_valid), 16'd1);
      chk("done_out_sum", 16'(io.out_sum), 16'(total % 4096));
      chk("done_out_ovf", 16'(io.out_ovf), 16'(total >= 4096));
      chk("done_in_ready", 16'(io.in_ready), 16'd0);
      chk("done_mac_a", 16'(io.mac_a), 16'd0);
      chk("done_busy", 16'(busy), 16'd1);
      if (h < hold) begin
        start = (h == 0);
        len   = 5'($urandom_range(1, 31));
        step();
        start = 1'b0;
      end
    end
    io.out_ready = 1'b1;
    step();
    io.out_ready = 1'b0;
    #1;
    chk_idle("after_job");
    chk("after_job_ovf", 16'(io.out_ovf), 16'd0);
  endtask

  task automatic load(input int n, input int lo);
    qa.delete();
    qb.delete();
    for (int i = 0; i < n; i++) begin
      qa.push_back(int'($urandom_range(lo, 15)));
      qb.push_back(int'($urandom_range(lo, 15)));
    end
  endtask

  initial begin
    rst_n        = 1'b0;
    start        = 1'b0;
    len          = '0;
    abort        = 1'b0;
    io.in_valid  = 1'b0;
    io.in_a      = '0;
    io.in_b      = '0;
    io.out_ready = 1'b0;
    #12;
    chk_idle("reset");
    chk("reset_ovf", 16'(io.out_ovf), 16'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // basic job: mac_c 0,15,240 then sum 254
    qa = '{3, 15, 2};
    qb = '{5, 15, 7};
    run_job(3, 0, 0, 0);

    // overflow: 19 x (15,15) = 4275 -> 179, carry on beat 19
    qa.delete(); qb.delete();
    for (int i = 0; i < 19; i++) begin qa.push_back(15); qb.push_back(15); end
    run_job(19, 0, 0, 1);

    // zero length
    run_job(0, 0, 0, 0);

    // stalls between beats, held result, start ignored in DONE
    qa = '{4, 1};
    qb = '{4, 9};
    run_job(2, 2, 0, 5);

    // abort in ACC after two beats, with a third beat presented
    start = 1'b1; len = 5'd4; step(); start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      io.in_valid = 1'b1;
      io.in_a = 4'(k + 5);
      io.in_b = 4'(k + 7);
      abort = (k == 2);
      step();
    end
    abort = 1'b0;
    io.in_valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk_idle("aborted");
      step();
    end
    qa = '{2};
    qb = '{3};
    run_job(1, 0, 0, 0);

    // abort while DONE with out_ready low, then abort+start in IDLE (start wins)
    qa = '{7};
    qb = '{9};
    start = 1'b1; len = 5'd1; step(); start = 1'b0;
    io.in_valid = 1'b1; io.in_a = 4'd7; io.in_b = 4'd9; step();
    io.in_valid = 1'b0;
    abort = 1'b1; step();
    #1;
    chk_idle("abort_done");
    start = 1'b1; len = 5'd0; step(); start = 1'b0; abort = 1'b0;
    #1;
    chk("abort_start_ovld", 16'(io.out_valid), 16'd1);
    chk("abort_start_sum", 16'(io.out_sum), 16'd0);
    io.out_ready = 1'b1; step(); io.out_ready = 1'b0;

    // random jobs, some biased toward overflow
    for (int j = 0; j < 12; j++) begin
      int n = int'($urandom_range(1, 31));
      load(n, (j % 3 == 0) ? 12 : 0);
      run_job(n, 0, 2, int'($urandom_range(0, 3)));
    end

    // reset asserted asynchronously mid-ACC
    start = 1'b1; len = 5'd5; step(); start = 1'b0;
    io.in_valid = 1'b1; io.in_a = 4'd9; io.in_b = 4'd9; step();
    #1;
    chk("pre_reset_macc", 16'(io.mac_c), 16'd81);
    #1;
    rst_n = 1'b0;
    #1;
    chk_idle("async_reset");
    io.in_valid = 1'b0;
    step();
    #2;
    rst_n = 1'b1;
    step();
    #1;
    chk_idle("post_reset");
    qa = '{6, 6};
    qb = '{6, 6};
    run_job(2, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
